// File: rtl/cavlc_coeff_assembler.sv
// CAVLC coefficient assembler: places decoded levels at their scan positions using run_before and streams 16 coefficients.
// Optional CAVLC_DEZIGZAG_EN: when defined, output is in raster order (inverse zigzag); otherwise it is in scan order.
module cavlc_coeff_assembler #(
  parameter int LEVEL_W = 13,
  parameter int RUN_W   = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic signed [LEVEL_W-1:0] LevelIn,
  input  logic                      LevelWr,
  input  logic        [RUN_W-1:0]   RunIn,
  input  logic                      RunWr,
  input  logic        [4:0]         TotalCoeff,
  input  logic        [4:0]         TotalZeros,
  input  logic                      BlockDone,
  output logic                      InReady,
  output logic signed [LEVEL_W-1:0] CoeffOut,
  output logic                      CoeffValid,
  input  logic                      CoeffReady,
  output logic                      CoeffLast,
  output logic                      Error
);

  typedef enum logic [1:0] {ST_COLLECT, ST_PLACE, ST_OUTPUT} state_t;

  function automatic logic [3:0] f_map(input logic [3:0] k);
`ifdef CAVLC_DEZIGZAG_EN
    case (k)
      4'd0:    return 4'd0;
      4'd1:    return 4'd1;
      4'd2:    return 4'd5;
      4'd3:    return 4'd6;
      4'd4:    return 4'd2;
      4'd5:    return 4'd4;
      4'd6:    return 4'd7;
      4'd7:    return 4'd12;
      4'd8:    return 4'd3;
      4'd9:    return 4'd8;
      4'd10:   return 4'd11;
      4'd11:   return 4'd13;
      4'd12:   return 4'd9;
      4'd13:   return 4'd10;
      4'd14:   return 4'd14;
      default: return 4'd15;
    endcase
`else
    return k;
`endif
  endfunction

  state_t                    r_state;
  logic signed [LEVEL_W-1:0] r_level [16];
  logic        [RUN_W-1:0]   r_run   [16];
  logic signed [LEVEL_W-1:0] r_block [16];
  logic        [4:0]         r_lcnt, r_rcnt, r_tc, r_i;
  logic signed [5:0]         r_pos;
  logic        [3:0]         r_k;
  logic signed [LEVEL_W-1:0] r_coeff_out;
  logic                      r_coeff_valid, r_coeff_last, r_error, r_in_ready, r_clr_pend;

  logic                      w_lwr_ok, w_rwr_ok, w_blk_err, w_in_err, w_busy_in;
  logic                      w_err_base, w_last_i, w_drop;
  logic        [4:0]         w_lcnt_nx, w_rcnt_nx;
  logic        [5:0]         w_sum;
  logic signed [LEVEL_W-1:0] w_level_i, w_first_out;
  logic        [RUN_W-1:0]   w_run_i;
  logic signed [5:0]         w_pos_nx;
  logic        [3:0]         w_map_first, w_map_nx;

  assign w_lwr_ok   = LevelWr && (r_lcnt != 5'd16);
  assign w_rwr_ok   = RunWr && (r_rcnt != 5'd16);
  assign w_lcnt_nx  = r_lcnt + {4'd0, w_lwr_ok};
  assign w_rcnt_nx  = r_rcnt + {4'd0, w_rwr_ok};
  assign w_sum      = {1'b0, TotalCoeff} + {1'b0, TotalZeros};
  assign w_blk_err  = (w_sum > 6'd16) || (w_lcnt_nx != TotalCoeff) ||
                      (({1'b0, w_rcnt_nx} + 6'd1) < {1'b0, TotalCoeff});
  assign w_in_err   = (LevelWr && !w_lwr_ok) || (RunWr && !w_rwr_ok);
  assign w_busy_in  = LevelWr || RunWr || BlockDone;
  // Error from the previous block survives until the new block shows its first activity.
  assign w_err_base = (r_clr_pend && (LevelWr || BlockDone)) ? 1'b0 : r_error;

  // Entries never written in this block read as zero.
  assign w_level_i   = (r_i < r_lcnt) ? r_level[r_i[3:0]] : '0;
  assign w_run_i     = (r_i < r_rcnt) ? r_run[r_i[3:0]] : '0;
  assign w_pos_nx    = r_pos - 6'sd1 - $signed({{(6-RUN_W){1'b0}}, w_run_i});
  assign w_last_i    = (r_i == r_tc - 5'd1);
  assign w_drop      = !w_last_i && w_pos_nx[5];
  assign w_map_first = f_map(4'd0);
  // The final placement lands on the same edge the first coefficient is loaded, so bypass it.
  assign w_first_out = (w_map_first == r_pos[3:0]) ? w_level_i : r_block[w_map_first];
  assign w_map_nx    = f_map(r_k + 4'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_COLLECT;
      r_lcnt        <= '0;
      r_rcnt        <= '0;
      r_tc          <= '0;
      r_i           <= '0;
      r_pos         <= '0;
      r_k           <= '0;
      r_coeff_out   <= '0;
      r_coeff_valid <= 1'b0;
      r_coeff_last  <= 1'b0;
      r_error       <= 1'b0;
      r_in_ready    <= 1'b1;
      r_clr_pend    <= 1'b0;
      for (int j = 0; j < 16; j++) r_block[j] <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_lwr_ok) r_level[r_lcnt[3:0]] <= LevelIn;
          if (w_rwr_ok) r_run[r_rcnt[3:0]] <= RunIn;
          r_lcnt  <= w_lcnt_nx;
          r_rcnt  <= w_rcnt_nx;
          r_error <= w_err_base | w_in_err | (BlockDone && w_blk_err);
          if (LevelWr || BlockDone) r_clr_pend <= 1'b0;
          if (BlockDone) begin
            r_tc       <= (TotalCoeff > 5'd16) ? 5'd16 : TotalCoeff;
            r_pos      <= (w_sum > 6'd16) ? 6'sd15 : $signed(w_sum - 6'd1);
            r_i        <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            for (int j = 0; j < 16; j++) r_block[j] <= '0;
            if (TotalCoeff == 5'd0) begin
              r_state       <= ST_OUTPUT;
              r_coeff_out   <= '0;
              r_coeff_valid <= 1'b1;
              r_coeff_last  <= 1'b0;
            end else begin
              r_state <= ST_PLACE;
            end
          end
        end
        ST_PLACE: begin
          r_block[r_pos[3:0]] <= w_level_i;
          r_error             <= r_error | w_busy_in | w_drop;
          if (w_last_i || w_drop) begin
            r_state       <= ST_OUTPUT;
            r_coeff_out   <= w_first_out;
            r_coeff_valid <= 1'b1;
            r_coeff_last  <= 1'b0;
          end else begin
            r_pos <= w_pos_nx;
            r_i   <= r_i + 5'd1;
          end
        end
        ST_OUTPUT: begin
          r_error <= r_error | w_busy_in;
          if (CoeffReady) begin
            if (r_k == 4'd15) begin
              r_state       <= ST_COLLECT;
              r_coeff_valid <= 1'b0;
              r_coeff_last  <= 1'b0;
              r_lcnt        <= '0;
              r_rcnt        <= '0;
              r_in_ready    <= 1'b1;
              r_clr_pend    <= 1'b1;
            end else begin
              r_k          <= r_k + 4'd1;
              r_coeff_out  <= r_block[w_map_nx];
              r_coeff_last <= (r_k == 4'd14);
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign InReady    = r_in_ready;
  assign CoeffOut   = r_coeff_out;
  assign CoeffValid = r_coeff_valid;
  assign CoeffLast  = r_coeff_last;
  assign Error      = r_error;

endmodule
